// File: rtl/phase_pkg.sv
// Shared types and constants for the phase scheduler: state encodings,
// error codes and default phase timeouts.
package phase_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_MEM    = 3'd2,
        ST_COMP   = 3'd3,
        ST_DISP   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_MEM  = 2'd1;
    localparam logic [1:0] ERR_COMP = 2'd2;
    localparam logic [1:0] ERR_DISP = 2'd3;

    localparam int DEF_CNT_W        = 10;
    localparam int DEF_SETTLE_CYC   = 4;
    localparam int DEF_MEM_TIMEOUT  = 50;
    localparam int DEF_COMP_TIMEOUT = 200;
    localparam int DEF_DISP_TIMEOUT = 500;

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on a phase change, otherwise counts up and
// saturates; expire_o flags the cycle on which the count equals limit_i.
module phase_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: always_comb assigns its output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == limit_i);

endmodule

// File: rtl/phase_scheduler.sv
// Handshake-driven memory -> compute -> display sequencer with per-phase timeouts.
// Define PHASE_LOOP_EN to loop DISP straight back to MEM for continuous frames.
module phase_scheduler
    import phase_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int COMP_TIMEOUT = DEF_COMP_TIMEOUT,
    parameter int DISP_TIMEOUT = DEF_DISP_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mem_done,
    input  logic       comp_done,
    input  logic       disp_done,
    output logic       en_mem,
    output logic       en_comp,
    output logic       en_disp,
    output logic       busy,
    output logic       error,
    output logic [1:0] err_code,
    output logic [2:0] phase
);

    state_e           state_q, state_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] limit;
    logic             expire;
    logic             en_mem_q, en_comp_q, en_disp_q, busy_q, error_q;

    // Limits are "last allowed count", so a phase lasts exactly N cycles.
    always_comb begin
        limit = '0;
        case (state_q)
            ST_SETTLE: limit = CNT_W'(SETTLE_CYC - 1);
            ST_MEM:    limit = CNT_W'(MEM_TIMEOUT - 1);
            ST_COMP:   limit = CNT_W'(COMP_TIMEOUT - 1);
            ST_DISP:   limit = CNT_W'(DISP_TIMEOUT - 1);
            default:   limit = '0;
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_d != state_q),
        .limit_i  (limit),
        .expire_o (expire)
    );

    // Priority in every phase: abort, then done, then timeout.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)       state_d = ST_IDLE;
                else if (expire) state_d = ST_MEM;
            end
            ST_MEM: begin
                if (abort)         state_d = ST_IDLE;
                else if (mem_done) state_d = ST_COMP;
                else if (expire) begin
                    state_d = ST_ERR;
                    err_d   = ERR_MEM;
                end
            end
            ST_COMP: begin
                if (abort)          state_d = ST_IDLE;
                else if (comp_done) state_d = ST_DISP;
                else if (expire) begin
                    state_d = ST_ERR;
                    err_d   = ERR_COMP;
                end
            end
            ST_DISP: begin
                if (abort) state_d = ST_IDLE;
                else if (disp_done) begin
`ifdef PHASE_LOOP_EN
                    state_d = ST_MEM;
`else
                    state_d = ST_IDLE;
`endif
                end else if (expire) begin
                    state_d = ST_ERR;
                    err_d   = ERR_DISP;
                end
            end
            ST_ERR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end else if (start) begin
                    state_d = ST_SETTLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the entering edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_q     <= ERR_NONE;
            en_mem_q  <= 1'b1;
            en_comp_q <= 1'b1;
            en_disp_q <= 1'b1;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            en_mem_q  <= !(state_d inside {ST_MEM, ST_COMP, ST_DISP});
            en_comp_q <= !(state_d inside {ST_COMP, ST_DISP});
            en_disp_q <= (state_d != ST_DISP);
            busy_q    <= (state_d inside {ST_SETTLE, ST_MEM, ST_COMP, ST_DISP});
            error_q   <= (state_d == ST_ERR);
        end
    end

    assign en_mem   = en_mem_q;
    assign en_comp  = en_comp_q;
    assign en_disp  = en_disp_q;
    assign busy     = busy_q;
    assign error    = error_q;
    assign err_code = err_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: a phase/age reference model predicts
// every cycle's outputs, a separate monitor compares them against the DUT.
module tb_phase_scheduler;

    localparam int S_IDLE   = 0;
    localparam int S_SETTLE = 1;
    localparam int S_MEM    = 2;
    localparam int S_COMP   = 3;
    localparam int S_DISP   = 4;
    localparam int S_ERR    = 5;
    localparam int SETTLE_CYC = 4;

    logic       clk = 1'b0;
    logic       rst, start, abort, mem_done, comp_done, disp_done;
    logic       en_mem, en_comp, en_disp, busy, error;
    logic [1:0] err_code;
    logic [2:0] phase;

    phase_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mem_done  (mem_done),
        .comp_done (comp_done),
        .disp_done (disp_done),
        .en_mem    (en_mem),
        .en_comp   (en_comp),
        .en_disp   (en_disp),
        .busy      (busy),
        .error     (error),
        .err_code  (err_code),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which phase we are in, how long we have been there.
    int m_state = S_IDLE;
    int m_age   = 0;
    int m_err   = 0;

    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int timeout_of(input int s);
        case (s)
            S_MEM:   return 50;
            S_COMP:  return 200;
            S_DISP:  return 500;
            default: return 0;
        endcase
    endfunction

    function automatic logic [9:0] expected_outputs();
        logic em, ec, ed, bz, er;
        em = !(m_state == S_MEM || m_state == S_COMP || m_state == S_DISP);
        ec = !(m_state == S_COMP || m_state == S_DISP);
        ed = !(m_state == S_DISP);
        bz = (m_state >= S_SETTLE && m_state <= S_DISP);
        er = (m_state == S_ERR);
        return {em, ec, ed, bz, er, 2'(m_err), 3'(m_state)};
    endfunction

    task automatic model_advance(input bit st, input bit ab, input bit md, input bit cd, input bit dd);
        int  nxt;
        bit  done;
        nxt = m_state;
        case (m_state)
            S_IDLE:   if (st && !ab) nxt = S_SETTLE;
            S_SETTLE: begin
                if (ab) nxt = S_IDLE;
                else if (m_age == SETTLE_CYC - 1) nxt = S_MEM;
            end
            S_MEM, S_COMP, S_DISP: begin
                done = (m_state == S_MEM) ? md : (m_state == S_COMP) ? cd : dd;
                if (ab) nxt = S_IDLE;
                else if (done) begin
                    if (m_state != S_DISP) nxt = m_state + 1;
`ifdef PHASE_LOOP_EN
                    else nxt = S_MEM;
`else
                    else nxt = S_IDLE;
`endif
                end else if (m_age == timeout_of(m_state) - 1) begin
                    nxt   = S_ERR;
                    m_err = m_state - 1;
                end
            end
            S_ERR: begin
                if (ab || st) begin
                    nxt   = ab ? S_IDLE : S_SETTLE;
                    m_err = 0;
                end
            end
            default: nxt = S_IDLE;
        endcase
        if (nxt != m_state) begin
            m_state = nxt;
            m_age   = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic step(input bit st, input bit ab, input bit md, input bit cd, input bit dd);
        @(negedge clk);
        start     = st;
        abort     = ab;
        mem_done  = md;
        comp_done = cd;
        disp_done = dd;
        model_advance(st, ab, md, cd, dd);
        exp_q.push_back(expected_outputs());
    endtask

    // Raise each done on the given age of its phase (-1 = never); stop early at (stop_state, stop_age).
    task automatic run(input int n, input int md_at, input int cd_at, input int dd_at,
                       input int stop_state, input int stop_age);
        for (int i = 0; i < n; i++) begin
            if (m_state == stop_state && m_age == stop_age) return;
            step(1'b0, 1'b0,
                 m_state == S_MEM  && m_age == md_at,
                 m_state == S_COMP && m_age == cd_at,
                 m_state == S_DISP && m_age == dd_at);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                check("outputs{en3,busy,error,err_code,phase}",
                      32'({en_mem, en_comp, en_disp, busy, error, err_code, phase}),
                      32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; mem_done = 1'b0; comp_done = 1'b0; disp_done = 1'b0;
        #1;
        check("reset_en",       32'({en_mem, en_comp, en_disp}), 32'b111);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_error",    32'(error),    32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);
        check("reset_phase",    32'(phase),    32'd0);
        #11 rst = 1'b0;

        // Normal run (loops three frames when PHASE_LOOP_EN is defined), then abort.
        step(1, 0, 0, 0, 0);
        run(160, 10, 30, 5, -1, 0);
        step(0, 1, 0, 0, 0);
        run(3, -1, -1, -1, -1, 0);

        // MEM timeout, restart from ERR, then abort.
        step(1, 0, 0, 0, 0);
        run(60, -1, -1, -1, -1, 0);
        step(1, 0, 0, 0, 0);
        run(3, -1, -1, -1, -1, 0);
        step(0, 1, 0, 0, 0);

        // comp_done on the timeout cycle wins.
        step(1, 0, 0, 0, 0);
        run(260, 0, 199, 0, -1, 0);
        step(0, 1, 0, 0, 0);

        // COMP and DISP timeouts, each cleared by abort.
        step(1, 0, 0, 0, 0);
        run(220, 0, -1, -1, -1, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        run(520, 0, 0, -1, -1, 0);
        step(0, 1, 0, 0, 0);

        // abort together with mem_done during MEM.
        step(1, 0, 0, 0, 0);
        run(20, -1, -1, -1, S_MEM, 3);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Asynchronous reset between clock edges in COMP.
        step(1, 0, 0, 0, 0);
        run(40, 10, -1, -1, S_COMP, 5);
        @(posedge clk);
        #3;
        start = 1'b0; abort = 1'b0; mem_done = 1'b0; comp_done = 1'b0; disp_done = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_en",    32'({en_mem, en_comp, en_disp}), 32'b111);
        check("async_rst_phase", 32'(phase), 32'd0);
        check("async_rst_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        m_state = S_IDLE; m_age = 0; m_err = 0;
        step(1, 0, 0, 0, 0);
        run(60, 10, 30, 5, -1, 0);
        step(0, 1, 0, 0, 0);

        // Random traffic, including stale and out-of-phase done levels.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);

        step(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
Handshake-driven sequencer for the memory → computation → display datapath. It replaces fixed-interval phase stepping with done-handshakes, per-phase timeouts, abort and an error state. The block drives the same active-low enables as the existing phase controller, so the memory, compute and display units need no changes. It sits at the top level between the board start/abort inputs and the three datapath units.

Parameters:
CNT_W, 10, width of the phase timeout counter
SETTLE_CYC, 4, cycles held in SETTLE before MEM (must be ≥1)
MEM_TIMEOUT, 50, maximum cycles allowed in MEM
COMP_TIMEOUT, 200, maximum cycles allowed in COMP
DISP_TIMEOUT, 500, maximum cycles allowed in DISP

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  run request; sampled only in IDLE or ERR
abort  in  1  return to IDLE from any state
mem_done  in  1  memory unit finished (level or pulse)
comp_done  in  1  compute unit finished
disp_done  in  1  display unit finished
en_mem  out  1  memory enable, active-low
en_comp  out  1  compute enable, active-low
en_disp  out  1  display enable, active-low
busy  out  1  high in SETTLE/MEM/COMP/DISP
error  out  1  high in ERR
err_code  out  2  0=none, 1=MEM timeout, 2=COMP timeout, 3=DISP timeout
phase  out  3  current state encoding (debug)

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cnt=0, err_code=0. Outputs en_*=1, busy=0, error=0, phase=0.
- States and encodings: IDLE=0, SETTLE=1, MEM=2, COMP=3, DISP=4, ERR=5. Codes 6 and 7 return to IDLE on the next edge.
- Outputs are a Moore decode of the state register and change on the edge that enters the state.
  - IDLE, SETTLE, ERR: en_mem=1, en_comp=1, en_disp=1.
  - MEM: en_mem=0.
  - COMP: en_mem=0, en_comp=0.
  - DISP: all three enables =0. Enables are cumulative, matching the existing controller.
- cnt clears on every state change and increments by 1 each cycle while the state is unchanged. It saturates at 2^CNT_W−1.
- IDLE: start=1 → SETTLE.
- SETTLE: → MEM when cnt==SETTLE_CYC−1, so SETTLE lasts exactly SETTLE_CYC cycles.
- MEM:
  - mem_done=1 → COMP.
  - Otherwise, if cnt==MEM_TIMEOUT−1 → ERR with err_code=1.
- COMP and DISP: same rule as MEM, using comp_done/COMP_TIMEOUT and disp_done/DISP_TIMEOUT. Error codes are 2 and 3.
- DISP exit on disp_done → IDLE (see Optional Feature).
- ERR:
  - Holds err_code.
  - start=1 → SETTLE and clears err_code.
  - abort=1 → IDLE and clears err_code.
- Priority within a cycle: abort > done > timeout. A done arriving on the timeout cycle counts as success.
- start is ignored while busy=1. done inputs are ignored outside their own phase, and a stale done held high does not skip phases.
- abort in IDLE has no effect.
- Reset mid-phase forces IDLE immediately and drops all enables high.

Optional Feature:
PHASE_LOOP_EN
- Defined: disp_done in DISP → MEM directly, skipping SETTLE, giving continuous frame operation. The loop exits only via abort, timeout or rst.
- Undefined: disp_done → IDLE.
- Ports are identical in both builds.

Decomposition:
- Package phase_pkg:
  - state enum and its 3-bit encodings
  - err_code constants ERR_NONE, ERR_MEM, ERR_COMP, ERR_DISP
  - default timeout constants
- Sub-module phase_timer: CNT_W-bit counter with clear, saturation and an expire compare against a limit input. phase_scheduler muxes the limit per state.

Test Plan:
- Normal run:
  - Stimulus: rst 1→0, start pulse. mem_done at MEM cycle 10, comp_done at COMP cycle 30, disp_done at DISP cycle 5.
  - Response: en pattern 111 → 011 (after 4 SETTLE cycles) → 001 → 000 → 111. busy high throughout; error stays 0.
- MEM timeout:
  - Stimulus: start, never assert mem_done.
  - Response: after exactly 50 MEM cycles, state=ERR, error=1, err_code=1, en=111.
  - Follow-up: start → SETTLE, err_code=0.
- Done-vs-timeout collision:
  - Stimulus: comp_done asserted on COMP cycle 199 (cnt=199).
  - Response: → DISP, no error.
- Abort priority:
  - Stimulus: abort and mem_done in the same cycle during MEM.
  - Response: → IDLE, en=111, busy=0.
- Async reset mid-COMP:
  - Stimulus: rst pulse between clock edges.
  - Response: en=111 and phase=0 immediately; start afterwards runs a full sequence.
- PHASE_LOOP_EN build:
  - Stimulus: three disp_done pulses.
  - Response: DISP→MEM three times with no SETTLE and busy never drops. abort then → IDLE.
